fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control unit and ALU in the MIPS micro-architecture.
- Holds the PC and issues one request per instruction to an instruction memory with variable latency.
- Presents the fetched word (opcode/funct/fields) to decode with a valid/ready handshake.
- Computes the next PC from the branch, zero and jump results returned for the instruction being consumed.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- stall  input  1  while 1, no new memory request is issued
- imem_req  output  1  one-cycle request strobe to instruction memory
- imem_addr  output  32  request address, always equal to pc
- imem_rvalid  input  1  memory returns data this cycle
- imem_rdata  input  32  returned instruction word
- instr_valid  output  1  instr holds a valid instruction
- instr_ready  input  1  downstream accepts instr this cycle
- instr  output  32  held instruction word to decode
- branch  input  1  control-unit branch for the held instr; sampled only on accept
- zero  input  1  ALU zero for the held instr; sampled only on accept
- jump  input  1  control-unit jump for the held instr; sampled only on accept
- pc  output  32  address of the current or held instruction
- pc_plus4  output  32  pc + 4, combinational
- retired  output  CNT_W  count of accepted instructions

Behaviour:
- Reset is asynchronous, active-low.
  - While rst_n=0: state=BOOT, pc=RESET_PC, instr=0, retired=0, imem_req=0, instr_valid=0.
  - Reset mid-operation aborts any outstanding request.
  - A late imem_rvalid after reset is ignored because it is sampled only in WAIT.
- State machine: BOOT, REQ, WAIT, HOLD.
  - BOOT -> REQ unconditionally on the first edge after reset release.
  - REQ: imem_req = !stall; imem_addr = pc. If stall=1, stay in REQ. Else -> WAIT.
  - WAIT: imem_req=0. On imem_rvalid=1, instr <= imem_rdata and -> HOLD; otherwise stay. Minimum memory latency is 1 cycle (req in cycle N, earliest rvalid in N+1).
  - HOLD: instr_valid=1; instr and pc are stable. On instr_ready=1 (accept): pc <= next_pc, retired <= retired+1, -> REQ. Otherwise stay in HOLD.
- Outputs are decoded combinationally from state.
  - instr_valid=1 only in HOLD.
  - imem_req=1 only in REQ with stall=0.
- Throughput: one instruction per 3 cycles at latency 1 (REQ, WAIT, HOLD with ready=1). No pipelining; at most one request outstanding.
- next_pc, all 32-bit with wrap-around modulo 2^32:
  - pc_plus4 = pc + 4.
  - If jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}. Jump has priority over branch.
  - Else if branch=1 and zero=1: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - Else: pc_plus4.
- pc[1:0] is always 00; every target formula above preserves this.
- X on branch, zero or jump outside an accept cycle has no effect.
- retired wraps to 0 after all-ones.
- stall affects only REQ; it does not freeze HOLD or WAIT.

Test Plan:
- Reset and sequential fetch: RESET_PC=0, latency 1, ready tied 1, all control inputs 0 -> imem_addr sequence 0x0, 0x4, 0x8 with requests 3 cycles apart; retired=3 after the third accept.
- Backpressure: hold instr_ready=0 for 5 cycles in HOLD -> instr and pc stable, no imem_req, retired unchanged; ready=1 -> single accept and next request to pc+4.
- Branch taken/not taken with pc=0x100 and instr imm=0xFFFE:
  - branch=1, zero=1 -> next request 0x0FC.
  - branch=1, zero=0 -> next request 0x104.
- Jump with pc=0x1000_0010, instr[25:0]=0x0000040, jump=1, branch=1, zero=1 -> next request 0x1000_0100 (jump wins).
- Variable latency and stall: rvalid after 4 cycles -> HOLD entered exactly the cycle after rvalid. stall=1 for 3 cycles in REQ -> imem_req low for those cycles and pc unchanged.
- Reset mid-operation: rst_n=0 in WAIT, then release; memory returns rvalid 1 cycle after release -> data ignored, the next request goes to RESET_PC, instr_valid=0 until the new fetch completes.
- Wrap-around: pc=0xFFFF_FFFC, no branch or jump -> next request 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response plus the decode-side
// valid/ready handshake and the control-unit/ALU results that steer the next PC.
interface fetch_unit_if #(
    parameter int CNT_W = 32
);
    logic             stall;
    logic             imem_req;
    logic [31:0]      imem_addr;
    logic             imem_rvalid;
    logic [31:0]      imem_rdata;
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr;
    logic             branch;
    logic             zero;
    logic             jump;
    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic [CNT_W-1:0] retired;

    modport master (
        input  stall, imem_rvalid, imem_rdata, instr_ready, branch, zero, jump,
        output imem_req, imem_addr, instr_valid, instr, pc, pc_plus4, retired
    );

    modport slave (
        output stall, imem_rvalid, imem_rdata, instr_ready, branch, zero, jump,
        input  imem_req, imem_addr, instr_valid, instr, pc, pc_plus4, retired
    );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: one outstanding request to a variable-latency
// instruction memory, held instruction handed to decode, next PC from branch/jump.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t           state;
    logic [31:0]      pc_q;
    logic [31:0]      instr_q;
    logic [CNT_W-1:0] retired_q;
    logic [31:0]      pc_plus4;
    logic [31:0]      branch_off;
    logic [31:0]      next_pc;

    assign pc_plus4   = pc_q + 32'd4;
    assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    // Jump outranks branch; both targets keep pc word-aligned.
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        next_pc = pc_plus4;
        if (bus.jump) begin
            next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (bus.branch && bus.zero) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_BOOT;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            case (state)
                ST_BOOT: state <= ST_REQ;
                ST_REQ: begin
                    if (!bus.stall) begin
                        state <= ST_WAIT;
                    end
                end
                // rvalid is only honoured here, so stale returns after reset are dropped.
                ST_WAIT: begin
                    if (bus.imem_rvalid) begin
                        instr_q <= bus.imem_rdata;
                        state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.instr_ready) begin
                        pc_q      <= next_pc;
                        retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        state     <= ST_REQ;
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

    assign bus.imem_req    = (state == ST_REQ) && !bus.stall;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (state == ST_HOLD);
    assign bus.instr       = instr_q;
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.retired     = retired_q;

endmodule
